bcd_to_bin_8: RTL

Sequential 3-digit BCD to 8-bit binary converter using reverse double dabble (shift right, subtract 3). It is the inverse of the combinational 8-bit binary-to-BCD converter. It sits on the input side of designs that accept decimal entry, such as keypad or switch digits, and need a binary value. It takes one BCD word per start pulse and returns the binary result after a fixed number of cycles, with overflow and invalid-digit flags.

---
 rtl/bcd_pkg.sv | 29 ++
 rtl/bcd_digit_corr.sv | 16 +
 rtl/bcd_to_bin_8.sv | 91 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
// Work register layout: {hundreds[18:17], tens[16:13], units[12:9], binary[8:0]}.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BIN_W       = 8;
    localparam int SHIFT_N     = 9;
    localparam int DEC_W       = 10;
    localparam int WORK_W      = DEC_W + SHIFT_N;
    localparam int CNT_W       = 4;

    localparam int TENS_LSB    = SHIFT_N + BCD_DIGIT_W;
    localparam int UNITS_LSB   = SHIFT_N;

    localparam logic [BCD_DIGIT_W-1:0] CORR_SUB    = 4'd3;
    localparam logic [BCD_DIGIT_W-1:0] CORR_THRESH = 4'd8;
    localparam logic [BCD_DIGIT_W-1:0] DIGIT_MAX   = 4'd9;

    function automatic logic bad_digit(input logic [BCD_DIGIT_W-1:0] d);
        return d > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Reverse double-dabble digit correction: digits of 8 or more drop by 3.
module bcd_digit_corr
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);

    always_comb begin
        q = d;
        if (d >= CORR_THRESH) begin
            q = d - CORR_SUB;
        end
    end

endmodule

// File: rtl/bcd_to_bin_8.sv
// Sequential 3-digit BCD to 8-bit binary converter (shift right, subtract 3).
// One conversion per accepted start; done pulses 10 edges after acceptance.
module bcd_to_bin_8
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DEC_W-1:0] dec,
    output logic [BIN_W-1:0] bin,
    output logic             ovf,
    output logic             err,
    output logic             busy,
    output logic             done
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WORK_W-1:0]   work;
    logic                err_lat;

    logic [WORK_W-1:0]      shifted;
    logic [WORK_W-1:0]      work_next;
    logic [BCD_DIGIT_W-1:0] tens_c;
    logic [BCD_DIGIT_W-1:0] units_c;

    bcd_digit_corr u_tens_corr (
        .d (shifted[TENS_LSB +: BCD_DIGIT_W]),
        .q (tens_c)
    );

    bcd_digit_corr u_units_corr (
        .d (shifted[UNITS_LSB +: BCD_DIGIT_W]),
        .q (units_c)
    );

    // Digit fields stay at fixed positions; the binary result accumulates below them.
    always_comb begin
        shifted   = work >> 1;
        work_next = shifted;
        work_next[TENS_LSB  +: BCD_DIGIT_W] = tens_c;
        work_next[UNITS_LSB +: BCD_DIGIT_W] = units_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            work    <= '0;
            err_lat <= 1'b0;
            bin     <= '0;
            ovf     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work    <= {dec, {SHIFT_N{1'b0}}};
                        cnt     <= CNT_W'(SHIFT_N);
                        err_lat <= bad_digit(dec[7:4]) | bad_digit(dec[3:0]);
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    bin   <= err_lat ? '0 : work[BIN_W-1:0];
                    ovf   <= err_lat ? 1'b0 : work[BIN_W];
                    err   <= err_lat;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
